// File: rtl/cnt_pkg.sv
// Shared types and constants for the cascaded-slice interval timer.
package cnt_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/cnt4_slice.sv
// One 4-bit synchronous up-counter slice; slices cascade through CI/CO.
module cnt4_slice
   import cnt_pkg::*;
(
   input  logic               CK,
   input  logic               nRST,
   input  logic [SLICE_W-1:0] D,
   input  logic               nL,
   input  logic               EN,
   input  logic               CI,
   input  logic               nCL,
   output logic [SLICE_W-1:0] Q,
   output logic               CO
);

   logic [SLICE_W-1:0] r_q;

   // Load beats clear, clear beats count.
   always_ff @(posedge CK) begin
      if (!nRST) begin
         r_q <= '0;
      end else if (!nL) begin
         r_q <= D;
      end else if (!nCL) begin
         r_q <= '0;
      end else if (EN && CI) begin
         r_q <= r_q + 1'b1;
      end
   end

   assign Q  = r_q;
   assign CO = (&r_q) & CI;

endmodule

// File: rtl/cnt_chain_ctrl.sv
// Interval timer: FSM, preset register and TICK/IRQ logic driving a chain of
// cnt4_slice counters that reload from the preset at terminal count.
module cnt_chain_ctrl
   import cnt_pkg::*;
#(
   parameter int SLICES = 3
)(
   input  logic                        CK,
   input  logic                        nRST,
   input  logic [SLICE_W*SLICES-1:0]   PRESET,
   input  logic                        WR_PRE,
   input  logic                        START,
   input  logic                        STOP,
   input  logic                        CLR,
   input  logic                        ONESHOT,
   input  logic                        CE,
   input  logic                        IRQ_ACK,
   output logic [SLICE_W*SLICES-1:0]   COUNT,
   output logic                        BUSY,
   output logic                        TICK,
   output logic                        IRQ
);

   localparam int W = SLICE_W * SLICES;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_preset;
   logic            r_tick;
   logic            r_irq;
   logic [W-1:0]    w_count;
   logic [SLICES:0] w_carry;
   logic            w_tc;
   logic            w_nl;
   logic            w_ncl;

   assign w_carry[0] = CE && (r_state == RUN);
   assign w_tc       = w_carry[SLICES];
   // Terminal count reloads the preset instead of wrapping to zero.
   assign w_nl       = !((r_state == LOAD) || w_tc);
   assign w_ncl      = !CLR;

   for (genvar k = 0; k < SLICES; k++) begin : g_slice
      cnt4_slice u_slice (
         .CK   (CK),
         .nRST (nRST),
         .D    (r_preset[k*SLICE_W +: SLICE_W]),
         .nL   (w_nl),
         .EN   (1'b1),
         .CI   (w_carry[k]),
         .nCL  (w_ncl),
         .Q    (w_count[k*SLICE_W +: SLICE_W]),
         .CO   (w_carry[k+1])
      );
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (START && !STOP) w_state_nxt = LOAD;
         LOAD: w_state_nxt = RUN;
         RUN: begin
            if (STOP)                    w_state_nxt = IDLE;
            else if (START)              w_state_nxt = LOAD;
            else if (w_tc && ONESHOT)    w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CK) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_preset <= '0;
         r_tick   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // A write racing a load lands after the load has used the old value.
         if (WR_PRE) r_preset <= PRESET;
         r_tick <= w_tc;
         r_irq  <= w_tc | (r_irq & !IRQ_ACK);
      end
   end

   assign COUNT = w_count;
   assign BUSY  = (r_state != IDLE);
   assign TICK  = r_tick;
   assign IRQ   = r_irq;

endmodule
